// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and receiver state encoding for the PS/2 key tracker.
package ps2_pkg;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] PS2_BAT     = 8'hAA;
  localparam logic [7:0] PS2_ACK     = 8'hFA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;
endpackage

// File: rtl/ps2_key_tracker_if.sv
// PS/2 line inputs plus decoded code / key-state outputs of the tracker.
interface ps2_key_tracker_if #(
  parameter int NUM_KEYS = 5
);
  logic                key_clk;
  logic                key_data;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                code_valid;
  logic [7:0]          code_byte;
  logic                code_ext;
  logic                code_brk;
  logic                frame_err;

  modport master (
    input  key_clk, key_data,
    output key_down, key_press, key_release,
    output code_valid, code_byte, code_ext, code_brk, frame_err
  );

  modport slave (
    output key_clk, key_data,
    input  key_down, key_press, key_release,
    input  code_valid, code_byte, code_ext, code_brk, frame_err
  );
endinterface

// File: rtl/ps2_key_tracker_rx_frame.sv
// PS/2 frame receiver: line synchronisers, fall detect, 11-bit frame FSM,
// odd-parity check and mid-frame watchdog.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1,
  parameter int TIMEOUT_CYC  = 20000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       key_clk_i,
  input  logic       key_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  // kc_q[1] is the synced clock, kc_q[2] its previous value
  logic [2:0] kc_q;
  logic [1:0] kd_q;
  logic       fall, din;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      kc_q <= '1;
      kd_q <= '1;
    end else begin
      kc_q <= {kc_q[1:0], key_clk_i};
      kd_q <= {kd_q[0], key_data_i};
    end
  end

  assign fall = kc_q[2] & ~kc_q[1];
  assign din  = kd_q[1];

  rx_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wdog_d       = '0;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    if (fall) begin
      unique case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = {din, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          if (din && (!CHECK_PARITY || (^{shift_q, par_q}))) byte_valid_o = 1'b1;
          else                                               frame_err_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // a stalled keyboard must not wedge the receiver mid-frame
      if (wdog_q == WD_LAST) begin
        state_d     = IDLE;
        frame_err_o = 1'b1;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  assign byte_o = shift_q;
endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: E0/F0 prefix decode, code registers and a per-key
// held/press/release table matched against KEY_CODES/KEY_EXT.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                        NUM_KEYS     = 5,
  parameter logic [8*NUM_KEYS-1:0]     KEY_CODES    = {8'h5a, 8'h4b, 8'h42, 8'h1b, 8'h1c},
  parameter logic [NUM_KEYS-1:0]       KEY_EXT      = '0,
  parameter bit                        CHECK_PARITY = 1'b1,
  parameter int                        TIMEOUT_CYC  = 20000
) (
  input  logic               clk_in,
  input  logic               rst,
  ps2_key_tracker_if.master  bus
);
  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_rx_frame #(
    .CHECK_PARITY (CHECK_PARITY),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) u_rx (
    .clk_in       (clk_in),
    .rst          (rst),
    .key_clk_i    (bus.key_clk),
    .key_data_i   (bus.key_data),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_err)
  );

  logic                ext_q, ext_d, brk_q, brk_d, code_v_d;
  logic                cv_q, fe_q, cext_q, cbrk_q;
  logic [7:0]          code_q;
  logic [NUM_KEYS-1:0] down_q, press_q, rel_q, hit, mk, bk;

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    code_v_d = 1'b0;
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_PFX_EXT)      ext_d = 1'b1;
      else if (rx_byte == PS2_PFX_BRK) brk_d = 1'b1;
      else begin
        code_v_d = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  // keys match on the incoming byte so they update alongside code_valid
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    assign hit[i] = code_v_d && (rx_byte == KEY_CODES[8*i +: 8]) && (ext_q == KEY_EXT[i]);
    assign mk[i]  = hit[i] & ~brk_q & ~down_q[i];
    assign bk[i]  = hit[i] &  brk_q &  down_q[i];
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
      code_q  <= '0;
      cext_q  <= 1'b0;
      cbrk_q  <= 1'b0;
      down_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      cv_q    <= code_v_d;
      fe_q    <= rx_err;
      if (code_v_d) begin
        code_q <= rx_byte;
        cext_q <= ext_q;
        cbrk_q <= brk_q;
      end
      down_q  <= (down_q | mk) & ~bk;
      press_q <= mk;
      rel_q   <= bk;
    end
  end

  assign bus.key_down    = down_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;
  assign bus.code_valid  = cv_q;
  assign bus.code_byte   = code_q;
  assign bus.code_ext    = cext_q;
  assign bus.code_brk    = cbrk_q;
  assign bus.frame_err   = fe_q;
endmodule
